hms_display: RTL
================

# hms_display

Display back-end for the stopwatch timing chain. Samples the packed hours/minutes/seconds word on a strobe and converts each field to two BCD digits with a sequential shift-add-3 converter. Drives a six-digit multiplexed common-anode seven-segment display, plus a colon that blinks on the half-second pulse. Sits directly downstream of the timing counter: `update` is fed from `sec_pulse` and `blink` from `half_sec_pulse`.

## Interface
- `SCAN_DIV`, 8: clock cycles each digit stays lit; minimum 2.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `HMS_time` in 20: packed time. Bits [18:12] are hours, [11:6] minutes, [5:0] seconds; bit 19 is ignored.
- `update` in 1: single-cycle sample strobe.
- `blink` in 1: single-cycle strobe that toggles the colon.
- `busy` out 1: high while a conversion runs.
- `bcd_valid` out 1: one-cycle pulse when `digits` is updated.
- `digits` out 24: {H tens, H ones, M tens, M ones, S tens, S ones}, 4-bit BCD each.
- `overrun` out 1: sticky; set when `update` arrives while `busy`.
- `seg_n` out 7: active-low segments in the order {g,f,e,d,c,b,a}.
- `an_n` out 6: active-low digit enables; bit 0 is the leftmost digit (H tens).
- `colon` out 1: colon drive, active-high.

## Operation
- **Reset values (while `reset`=0):**
  - `busy`, `bcd_valid`, `overrun`, `colon` = 0.
  - `digits` = 0.
  - `seg_n` = 7'h7F, `an_n` = 6'h3F.
  - Scan index and divider = 0.
- **Conversion FSM:**
  - States are IDLE, CONV, DONE.
  - IDLE + `update` → CONV. `HMS_time` is latched and clamped: hours above 99 become 99; minutes or seconds above 59 become 59. Field pointer = H, bit counter = 0.
  - CONV performs one shift-add-3 step per cycle on a 7-bit field (minutes and seconds are zero-extended). After 7 steps it stores that field's two BCD digits in a staging register and advances H→M→S. After the 21st step → DONE.
  - DONE copies staging into `digits`, pulses `bcd_valid`, then → IDLE.
- **Strobe handling:**
  - `update` in CONV or DONE is dropped and sets `overrun`. Only reset clears `overrun`.
  - `update` in IDLE with `bcd_valid` high is accepted normally.
- **Outputs during conversion:**
  - `busy` = 1 in CONV and DONE.
  - `digits` holds its old value until DONE, so the display never shows a partial result.
- **Scan:**
  - The divider counts 0..`SCAN_DIV`-1. On wrap, the digit index advances 0..5, then wraps to 0.
  - `an_n` = ~(1<<index).
  - `seg_n` is the decoded `digits` nibble for the current index.
  - Decode table: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex).
  - Nibbles above 9 are blanked (7F).
- **Colon:** toggles on every `blink` pulse. `blink` and `update` in the same cycle are independent of each other.
- **Reset mid-conversion:** the conversion is aborted, `bcd_valid` does not fire, and `digits` = 0.

## Timing
- Latency: if `update` is sampled at edge N, `busy` is high from N+1 through N+22, `bcd_valid` is high for the cycle after edge N+22, and `digits` is valid from N+22.
- Throughput: one conversion per 23 cycles, far above the 1 Hz strobe rate.
- `seg_n`, `an_n` and `colon` are registered. `seg_n` and `an_n` change on the same edge, so there is no ghosting.
- A full refresh takes 6×`SCAN_DIV` cycles.

## Configuration
- Macro: `HMS_DISPLAY_LZB_EN`.
- Defined: leading-zero blanking. When the H tens nibble is 0, `seg_n` = 7F during index 0; `an_n` still scans.
- Undefined: every digit is decoded, so H tens of 0 shows 40.
- `digits` is identical in both builds.

## Structure
- Package `hms_display_pkg`:
  - field width constants (HRS_W=7, MIN_W=6, SEC_W=6);
  - clamp limits (99, 59);
  - the FSM state enum;
  - the seven-segment decode constants and blank code.
- Sub-module `bin2bcd_seq`:
  - 7-bit input, 8-bit BCD output, 7 cycles per conversion;
  - `start`/`done` handshake.
- The top module sequences `bin2bcd_seq` over the three fields and owns the scan, colon and overrun logic.

## Test plan
- Reset: assert `reset`=0 mid-scan → `seg_n`=7F, `an_n`=3F, `digits`=0, `busy`=`colon`=`overrun`=0, all asserted asynchronously.
- Basic conversion: `HMS_time` H=12 M=34 S=56 with a 1-cycle `update` → `busy` high for 22 cycles, then `bcd_valid` pulses once, `digits`=24'h123456.
- Clamping: H=127 M=63 S=63 → `digits`=24'h995959.
- Overrun: a second `update` (H=1) 5 cycles after the first (H=12 M=34 S=56) → `overrun`=1 and stays 1, `digits`=24'h123456, only one `bcd_valid`.
- Scan and colon: `SCAN_DIV`=4 with `digits`=24'h000102 → `an_n` sequence 3E,3D,3B,37,2F,1F, 4 cycles each. H tens shows `seg_n`=7F with `HMS_DISPLAY_LZB_EN` defined and 40 without. S ones shows 24. Three `blink` pulses leave `colon`=1.
- Reset mid-conversion: `reset`=0 ten cycles after `update` → no `bcd_valid`, `digits`=0, FSM in IDLE after release.

Source files
------------

// File: rtl/hms_display_pkg.sv
// Shared types and constants for the hms_display back-end: field widths,
// clamp limits, FSM/field enums, seven-segment codes and the shift-add-3 step.
package hms_display_pkg;

  localparam int unsigned HRS_W = 7;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned SEC_W = 6;

  localparam logic [HRS_W-1:0] HRS_MAX = 7'd99;
  localparam logic [MIN_W-1:0] MS_MAX  = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    FLD_H,
    FLD_M,
    FLD_S
  } field_e;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // One double-dabble step: add-3 correction on both nibbles, then shift in b
  function automatic logic [7:0] bcd_step(input logic [7:0] acc, input logic b);
    logic [7:0] t;
    t = acc;
    if (t[3:0] >= 4'd5) t[3:0] = t[3:0] + 4'd3;
    if (t[7:4] >= 4'd5) t[7:4] = t[7:4] + 4'd3;
    return {t[6:0], b};
  endfunction

endpackage

// File: rtl/hms_display_bin2bcd_seq.sv
// Sequential 7-bit binary to two-digit BCD converter, one shift-add-3 step
// per cycle; the start cycle already performs the first step.
module bin2bcd_seq
  import hms_display_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] bin,
  output logic [7:0] bcd,
  output logic       done
);

  logic [6:0] sh;
  logic [7:0] acc;
  logic [2:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= bcd_step(8'h00, bin[6]);
      sh  <= {bin[5:0], 1'b0};
      cnt <= 3'd1;
    end else if (cnt != 3'd0 && cnt != 3'd7) begin
      acc <= bcd_step(acc, sh[6]);
      sh  <= {sh[5:0], 1'b0};
      cnt <= cnt + 3'd1;
    end
  end

  assign bcd  = acc;
  assign done = (cnt == 3'd7);

endmodule

// File: rtl/hms_display.sv
// Stopwatch display back-end: clamps and BCD-converts H/M/S on update, then
// scans six common-anode digits plus a blinking colon.
// Optional leading-zero blanking of H tens: define HMS_DISPLAY_LZB_EN.
module hms_display
  import hms_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] HMS_time,
  input  logic        update,
  input  logic        blink,
  output logic        busy,
  output logic        bcd_valid,
  output logic [23:0] digits,
  output logic        overrun,
  output logic [6:0]  seg_n,
  output logic [5:0]  an_n,
  output logic        colon
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_e           state, state_nx;
  field_e           field;
  logic [2:0]       bit_cnt;
  logic [HRS_W-1:0] hrs_q;
  logic [MIN_W-1:0] min_q;
  logic [SEC_W-1:0] sec_q;
  logic [7:0]       stage_h, stage_m;

  logic             conv_start, conv_done;
  logic [6:0]       conv_bin;
  logic [7:0]       conv_bcd;

  logic [DIV_W-1:0] div;
  logic [2:0]       idx;
  logic [3:0]       nib;
  logic [6:0]       seg_nx;
  logic             unused_msb;

  assign unused_msb = HMS_time[19];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (update) state_nx = ST_CONV;
      ST_CONV: if (field == FLD_S && bit_cnt == 3'd6) state_nx = ST_DONE;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy       = (state != ST_IDLE);
  assign conv_start = (state == ST_CONV) && (bit_cnt == 3'd0);

  always_comb begin
    conv_bin = hrs_q;
    case (field)
      FLD_M:   conv_bin = {1'b0, min_q};
      FLD_S:   conv_bin = {1'b0, sec_q};
      default: conv_bin = hrs_q;
    endcase
  end

  bin2bcd_seq u_bin2bcd (
    .clock (clock),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_bin),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // Starting the next field and banking the previous one share an edge, so the
  // three fields run back-to-back in 21 cycles with no idle step in between.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      field     <= FLD_H;
      bit_cnt   <= '0;
      hrs_q     <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      stage_h   <= '0;
      stage_m   <= '0;
      digits    <= '0;
      bcd_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      if (update && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (update) begin
            hrs_q   <= (HMS_time[18:12] > HRS_MAX) ? HRS_MAX : HMS_time[18:12];
            min_q   <= (HMS_time[11:6]  > MS_MAX)  ? MS_MAX  : HMS_time[11:6];
            sec_q   <= (HMS_time[5:0]   > MS_MAX)  ? MS_MAX  : HMS_time[5:0];
            field   <= FLD_H;
            bit_cnt <= '0;
          end
        end
        ST_CONV: begin
          if (conv_start && conv_done) begin
            case (field)
              FLD_M:   stage_h <= conv_bcd;
              FLD_S:   stage_m <= conv_bcd;
              default: ;
            endcase
          end
          if (bit_cnt == 3'd6) begin
            bit_cnt <= '0;
            if (field == FLD_H)      field <= FLD_M;
            else if (field == FLD_M) field <= FLD_S;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        ST_DONE: begin
          digits    <= {stage_h, stage_m, conv_bcd};
          bcd_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nib = '0;
    case (idx)
      3'd0:    nib = digits[23:20];
      3'd1:    nib = digits[19:16];
      3'd2:    nib = digits[15:12];
      3'd3:    nib = digits[11:8];
      3'd4:    nib = digits[7:4];
      default: nib = digits[3:0];
    endcase
    seg_nx = seg_decode(nib);
`ifdef HMS_DISPLAY_LZB_EN
    if (idx == 3'd0 && nib == 4'd0) seg_nx = SEG_BLANK;
`else
    seg_nx = seg_decode(nib);
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div   <= '0;
      idx   <= '0;
      seg_n <= SEG_BLANK;
      an_n  <= '1;
      colon <= 1'b0;
    end else begin
      if (div == DIV_W'(SCAN_DIV - 1)) begin
        div <= '0;
        idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
      end else begin
        div <= div + DIV_W'(1);
      end
      seg_n <= seg_nx;
      an_n  <= ~(6'b1 << idx);
      if (blink) colon <= ~colon;
    end
  end

endmodule
